// File: rtl/fpu_mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle FPU sequencer: op codes, FSM states
// and the canonical quiet NaN returned on error.
package fpu_mc_sequencer_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_FDIV  = 2'b00;
   localparam op_t OP_FSQRT = 2'b01;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_DONE = 2'b10,
      S_GAP  = 2'b11
   } state_t;

   function automatic logic op_is_legal(input op_t op);
      return (op == OP_FDIV) || (op == OP_FSQRT);
   endfunction

endpackage

// File: rtl/fpu_mc_sequencer_if.sv
// Issue, unit and writeback signals between the execute stage, the FDIV/FSQRT
// units and the sequencer. The sequencer uses the slave modport.
interface fpu_mc_sequencer_if;
   import fpu_mc_sequencer_pkg::*;

   logic        issue_valid_i;
   logic        issue_ready_o;
   op_t         issue_op_i;
   logic [4:0]  issue_rd_i;
   logic        flush_i;
   logic        divEnable_o;
   logic        sqrtEnable_o;
   logic        divReady_i;
   logic        sqrtReady_i;
   logic [31:0] divOut_i;
   logic [31:0] sqrtOut_i;
   logic        result_valid_o;
   logic        result_ready_i;
   logic [31:0] result_o;
   logic [4:0]  result_rd_o;
   logic        result_err_o;
   logic        busy_o;

   modport slave (
      input  issue_valid_i, issue_op_i, issue_rd_i, flush_i,
      input  divReady_i, sqrtReady_i, divOut_i, sqrtOut_i, result_ready_i,
      output issue_ready_o, divEnable_o, sqrtEnable_o,
      output result_valid_o, result_o, result_rd_o, result_err_o, busy_o
   );

   modport master (
      output issue_valid_i, issue_op_i, issue_rd_i, flush_i,
      output divReady_i, sqrtReady_i, divOut_i, sqrtOut_i, result_ready_i,
      input  issue_ready_o, divEnable_o, sqrtEnable_o,
      input  result_valid_o, result_o, result_rd_o, result_err_o, busy_o
   );

endinterface

// File: rtl/fpu_mc_sequencer.sv
// Runs one FDIV/FSQRT op at a time: holds the unit enable until its ready
// pulse, returns the result over valid/ready, and keeps enables low between ops.
module fpu_mc_sequencer
   import fpu_mc_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int GAP_CYCLES     = 1,
   parameter int CNT_W          = 7
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   fpu_mc_sequencer_if.slave     bus
);

   state_t            r_state;
   op_t               r_op;
   logic [4:0]        r_rd;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_div_en;
   logic              r_sqrt_en;
   logic              r_valid;
   logic              r_acc;
   logic              r_err;
   logic [31:0]       r_result;

   logic              w_issue_ready;
   logic              w_hs;
   logic              w_sel_ready;
   logic [31:0]       w_sel_out;
   logic              w_timeout;
   logic              w_gap_done;
   logic              w_accept;

   // Accept a new op only from IDLE and never while a flush is pending.
   always_comb begin
      w_issue_ready = 1'b0;
      if ((r_state == S_IDLE) && !bus.flush_i) begin
         w_issue_ready = 1'b1;
      end else begin
         w_issue_ready = 1'b0;
      end
   end

   assign w_hs        = bus.issue_valid_i & w_issue_ready;
   assign w_sel_ready = (r_op == OP_FSQRT) ? bus.sqrtReady_i : bus.divReady_i;
   assign w_sel_out   = (r_op == OP_FSQRT) ? bus.sqrtOut_i   : bus.divOut_i;
   assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   // The current cycle is itself an enable-low cycle, hence the +1.
   assign w_gap_done  = (({1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1}) >= (CNT_W + 1)'(GAP_CYCLES));
   assign w_accept    = r_valid & bus.result_ready_i;

   // Sequencer state, shared timeout/gap counter, enables and result capture.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state   <= S_IDLE;
         r_op      <= 2'b00;
         r_rd      <= 5'd0;
         r_cnt     <= '0;
         r_div_en  <= 1'b0;
         r_sqrt_en <= 1'b0;
         r_valid   <= 1'b0;
         r_acc     <= 1'b0;
         r_err     <= 1'b0;
         r_result  <= 32'h0000_0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_op  <= bus.issue_op_i;
                  r_rd  <= bus.issue_rd_i;
                  r_cnt <= '0;
                  r_acc <= 1'b0;
                  if (op_is_legal(bus.issue_op_i)) begin
                     r_state   <= S_WAIT;
                     r_div_en  <= (bus.issue_op_i == OP_FDIV);
                     r_sqrt_en <= (bus.issue_op_i == OP_FSQRT);
                  end else begin
                     r_state  <= S_DONE;
                     r_valid  <= 1'b1;
                     r_result <= QNAN;
                     r_err    <= 1'b1;
                  end
               end
            end
            S_WAIT: begin
               if (bus.flush_i) begin
                  r_state   <= S_GAP;
                  r_div_en  <= 1'b0;
                  r_sqrt_en <= 1'b0;
                  r_cnt     <= '0;
               end else if (w_sel_ready || w_timeout) begin
                  r_state   <= S_DONE;
                  r_div_en  <= 1'b0;
                  r_sqrt_en <= 1'b0;
                  r_valid   <= 1'b1;
                  r_cnt     <= '0;
                  r_result  <= w_sel_ready ? w_sel_out : QNAN;
                  r_err     <= ~w_sel_ready;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (bus.flush_i) begin
                  r_state  <= S_GAP;
                  r_valid  <= 1'b0;
                  r_acc    <= 1'b0;
                  r_cnt    <= '0;
                  r_result <= 32'h0000_0000;
                  r_err    <= 1'b0;
               end else begin
                  // Valid drops on acceptance even if the gap still holds us here.
                  if (w_accept) begin
                     r_valid <= 1'b0;
                     r_acc   <= 1'b1;
                  end
                  if ((r_acc || w_accept) && w_gap_done) begin
                     r_state <= S_IDLE;
                     r_acc   <= 1'b0;
                     r_cnt   <= '0;
                  end else if (!w_gap_done) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_GAP: begin
               if (bus.flush_i) begin
                  r_cnt <= '0;
               end else if (w_gap_done) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_div_en  <= 1'b0;
               r_sqrt_en <= 1'b0;
               r_valid   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.issue_ready_o  = w_issue_ready;
   assign bus.divEnable_o    = r_div_en;
   assign bus.sqrtEnable_o   = r_sqrt_en;
   assign bus.result_valid_o = r_valid;
   assign bus.result_o       = r_result;
   assign bus.result_rd_o    = r_rd;
   assign bus.result_err_o   = r_err;
   assign bus.busy_o         = (r_state != S_IDLE);

endmodule
